// File: rtl/silife_max7219_pkg.sv
// Shared constants and types for the MAX7219 display sequencer.
// Register addresses, the init word list and the FSM encodings.
package silife_max7219_pkg;

  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  localparam int INIT_LEN = 5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_ROW,
    ST_CS_LOW,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_NEXT_WORD,
    ST_CS_HIGH,
    ST_GAP
  } state_t;

  // Word source for the group in progress.
  typedef enum logic [1:0] {
    MODE_INIT,
    MODE_INTEN,
    MODE_ROW
  } mode_t;

  // Init list in send order; entry 3 carries the intensity sampled at group start.
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] inten);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {4'h0, REG_SHUTDOWN,  8'h01};
      3'd1:    w = {4'h0, REG_DECODE,    8'h00};
      3'd2:    w = {4'h0, REG_SCANLIMIT, 8'h07};
      3'd3:    w = {4'h0, REG_INTENSITY, 4'h0, inten};
      default: w = {4'h0, REG_TEST,      8'h00};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/silife_max7219.sv
// MAX7219 chain sequencer: init once after reset, then one CS-framed group per row
// on each refresh, feeding a 16-bit SPI master through its start/busy handshake.
module silife_max7219
  import silife_max7219_pkg::*;
#(
  parameter int CHIPS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_refresh,
  input  logic [3:0]         i_intensity,
  output logic [2:0]         o_frame_addr,
  input  logic [8*CHIPS-1:0] i_frame_data,
  output logic [15:0]        o_spi_word,
  output logic               o_spi_start,
  input  logic               i_spi_busy,
  output logic               o_cs,
  output logic               o_busy
);

  state_t      state;
  mode_t       mode;
  logic [2:0]  item;
  logic [2:0]  chip;
  logic [63:0] row_reg;
  logic [3:0]  group_int;
  logic [3:0]  last_int;
  logic        last_int_valid;
  logic        pending;

  logic        pending_now;
  logic        need_int;
  logic [3:0]  row_num;
  logic [15:0] word_sel;

  always_comb begin
    pending_now = pending | i_refresh;
    need_int    = !last_int_valid || (i_intensity != last_int);
    row_num     = {1'b0, item} + REG_DIGIT0;
    word_sel    = 16'h0000;
    case (mode)
      MODE_INIT:  word_sel = init_word(item, group_int);
      MODE_INTEN: word_sel = {4'h0, REG_INTENSITY, 4'h0, group_int};
      MODE_ROW:   word_sel = {4'h0, row_num, row_reg[{chip, 3'b000} +: 8]};
      default:    word_sel = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_CS_LOW;
      mode           <= MODE_INIT;
      item           <= 3'd0;
      chip           <= 3'd0;
      row_reg        <= 64'h0;
      group_int      <= 4'h0;
      last_int       <= 4'h0;
      last_int_valid <= 1'b0;
      pending        <= 1'b0;
      o_frame_addr   <= 3'd0;
      o_spi_word     <= 16'h0000;
      o_spi_start    <= 1'b0;
      o_cs           <= 1'b1;
      o_busy         <= 1'b1;
    end else begin
      if (i_refresh && state != ST_IDLE) pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (i_refresh) begin
            o_busy <= 1'b1;
            if (need_int) begin
              mode  <= MODE_INTEN;
              state <= ST_CS_LOW;
            end else begin
              mode         <= MODE_ROW;
              item         <= 3'd0;
              o_frame_addr <= 3'd0;
              state        <= ST_LOAD_ROW;
            end
          end
        end

        ST_LOAD_ROW: state <= ST_CS_LOW;

        // Row data for the current address is valid here; snapshot it for the group.
        ST_CS_LOW: begin
          o_cs      <= 1'b0;
          chip      <= 3'(CHIPS - 1);
          group_int <= i_intensity;
          if (mode == MODE_ROW) row_reg <= 64'(i_frame_data);
          state     <= ST_START;
        end

        ST_START: begin
          o_spi_start <= 1'b1;
          o_spi_word  <= word_sel;
          state       <= ST_WAIT_HI;
        end

        ST_WAIT_HI: begin
          o_spi_start <= 1'b0;
          if (i_spi_busy) state <= ST_WAIT_LO;
        end

        // Raise LOAD as soon as the last word's busy drops, so SCK is already idle.
        ST_WAIT_LO: begin
          if (!i_spi_busy) begin
            if (chip == 3'd0) o_cs <= 1'b1;
            state <= ST_NEXT_WORD;
          end
        end

        ST_NEXT_WORD: begin
          if (chip == 3'd0) begin
            state <= ST_CS_HIGH;
          end else begin
            chip  <= chip - 3'd1;
            state <= ST_START;
          end
        end

        ST_CS_HIGH: begin
          state <= ST_GAP;
          if (mode == MODE_INIT && item == 3'd3) begin
            last_int       <= group_int;
            last_int_valid <= 1'b1;
          end
          if ((mode == MODE_INIT && item != 3'(INIT_LEN - 1)) ||
              (mode == MODE_ROW && item != 3'd7)) begin
            item         <= item + 3'd1;
            o_frame_addr <= item + 3'd1;
          end else if (mode == MODE_INTEN) begin
            last_int       <= group_int;
            last_int_valid <= 1'b1;
            mode           <= MODE_ROW;
            item           <= 3'd0;
            o_frame_addr   <= 3'd0;
          end else if (pending_now) begin
            // Back-to-back frame: no IDLE cycle, busy stays high.
            pending <= 1'b0;
            if (need_int) begin
              mode <= MODE_INTEN;
            end else begin
              mode         <= MODE_ROW;
              item         <= 3'd0;
              o_frame_addr <= 3'd0;
            end
          end else begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_GAP: state <= ST_CS_LOW;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_silife_max7219.sv
// Directed bench for silife_max7219 with a behavioural SPI master, a row memory
// and a CS-window monitor that decodes words per window into a scoreboard.
module tb_silife_max7219;

  localparam int CHIPS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_refresh = 1'b0;
  logic [3:0]  i_intensity = 4'h5;
  logic [2:0]  o_frame_addr;
  logic [15:0] i_frame_data = 16'h0;
  logic [15:0] o_spi_word;
  logic        o_spi_start;
  logic        i_spi_busy;
  logic        o_cs;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  silife_max7219 #(.CHIPS(CHIPS)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_refresh    (i_refresh),
    .i_intensity  (i_intensity),
    .o_frame_addr (o_frame_addr),
    .i_frame_data (i_frame_data),
    .o_spi_word   (o_spi_word),
    .o_spi_start  (o_spi_start),
    .i_spi_busy   (i_spi_busy),
    .o_cs         (o_cs),
    .o_busy       (o_busy)
  );

  // Row memory with one cycle of read latency.
  logic [15:0] grid [8];
  always @(posedge clk) i_frame_data <= grid[o_frame_addr];

  // SPI master model: busy rises 1 cycle after start, falls 35 cycles after start.
  int   spi_cnt;
  logic sck;
  always @(posedge clk) begin
    if (reset) begin
      i_spi_busy <= 1'b0;
      spi_cnt    <= 0;
    end else if (i_spi_busy) begin
      if (spi_cnt == 34) begin
        i_spi_busy <= 1'b0;
        spi_cnt    <= 0;
      end else begin
        spi_cnt <= spi_cnt + 1;
      end
    end else if (o_spi_start) begin
      i_spi_busy <= 1'b1;
      spi_cnt    <= 1;
    end
  end
  assign sck = i_spi_busy && (spi_cnt >= 2) && (spi_cnt <= 33) && spi_cnt[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Window monitor
  logic [15:0] cur_words[$];
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic        cs_prev = 1'b1;
  logic        busy_prev = 1'b0;
  logic        sck_prev = 1'b0;
  logic [15:0] word_at_start = 16'h0;
  int          cs_hi_cnt = 2;
  int          sck_bad = 0;

  always @(negedge clk) begin
    if (reset) begin
      cur_words.delete();
      cs_prev   = 1'b1;
      cs_hi_cnt = 2;
      busy_prev = 1'b0;
      sck_prev  = 1'b0;
      sck_bad   = 0;
    end else begin
      if (o_spi_start) begin
        check("start_while_busy", {30'h0, busy_prev, i_spi_busy}, 32'h0);
        check("start_cs_low", {31'h0, o_cs}, 32'h0);
        cur_words.push_back(o_spi_word);
        word_at_start = o_spi_word;
      end
      if (busy_prev && !i_spi_busy) check("word_hold", {16'h0, o_spi_word}, {16'h0, word_at_start});
      if (o_cs && (sck !== sck_prev)) sck_bad++;
      if (cs_prev && !o_cs) begin
        check("cs_high_gap", {31'h0, (cs_hi_cnt >= 2)}, 32'h1);
        check("sck_quiet", sck_bad, 0);
      end
      if (!cs_prev && o_cs) begin
        check("window_len", cur_words.size(), CHIPS);
        foreach (cur_words[i]) got_q.push_back(cur_words[i]);
        cur_words.delete();
      end
      cs_hi_cnt = o_cs ? cs_hi_cnt + 1 : 0;
      cs_prev   = o_cs;
      busy_prev = i_spi_busy;
      sck_prev  = sck;
    end
  end

  task automatic pulse_refresh();
    @(posedge clk); #1 i_refresh = 1'b1;
    @(posedge clk); #1 i_refresh = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_busy && n < max_cycles);
    check({tag, "_timeout"}, {31'h0, o_busy}, 32'h0);
  endtask

  task automatic push_group(input logic [15:0] w);
    for (int c = 0; c < CHIPS; c++) exp_q.push_back(w);
  endtask

  task automatic push_init(input logic [3:0] inten);
    push_group(16'h0C01);
    push_group(16'h0900);
    push_group(16'h0B07);
    push_group({12'h0A0, inten});
    push_group(16'h0F00);
  endtask

  // Chip 1 (upper byte) is farthest and goes out first.
  task automatic push_rows();
    for (int r = 0; r < 8; r++) begin
      logic [3:0] reg_n;
      logic [15:0] g;
      reg_n = 4'(r + 1);
      g = grid[r];
      exp_q.push_back({4'h0, reg_n, g[15:8]});
      exp_q.push_back({4'h0, reg_n, g[7:0]});
    end
  endtask

  task automatic compare_windows(input string tag);
    int n;
    check({tag, "_words"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_w%0d", tag, i), {16'h0, got_q[i]}, {16'h0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    for (int r = 0; r < 8; r++) grid[r] = {8'(8'hA0 + r), 8'(8'h50 + r)};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", {31'h0, o_cs}, 32'h1);
    check("rst_busy", {31'h0, o_busy}, 32'h1);
    check("rst_start", {31'h0, o_spi_start}, 32'h0);
    check("rst_word", {16'h0, o_spi_word}, 32'h0);
    check("rst_addr", {29'h0, o_frame_addr}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // Init sequence
    push_init(4'h5);
    wait_idle("init", 3000);
    compare_windows("init");
    check("idle_cs", {31'h0, o_cs}, 32'h1);

    // Plain frame, no intensity group
    push_rows();
    pulse_refresh();
    wait_idle("frame", 3000);
    compare_windows("frame");

    // Intensity change then no-change frame
    i_intensity = 4'hF;
    push_group(16'h0A0F);
    push_rows();
    pulse_refresh();
    wait_idle("inten", 3000);
    compare_windows("inten");
    push_rows();
    pulse_refresh();
    wait_idle("inten_same", 3000);
    compare_windows("inten_same");

    // Refresh during a frame: exactly one more frame, busy never drops between
    for (int r = 0; r < 8; r++) grid[r] = {8'(8'h11 * r), 8'(8'hF0 - r)};
    push_rows();
    push_rows();
    pulse_refresh();
    repeat (100) @(posedge clk);
    pulse_refresh();
    repeat (50) @(posedge clk);
    pulse_refresh();
    repeat (50) @(posedge clk);
    pulse_refresh();
    wait_idle("merge", 4000);
    compare_windows("merge");
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("merge_no_more", got_q.size(), 0);
    check("merge_idle", {31'h0, o_busy}, 32'h0);

    // Reset mid-frame during row 4 with a refresh pending
    begin
      int n = 0;
      pulse_refresh();
      repeat (30) @(posedge clk);
      pulse_refresh();
      do begin
        @(negedge clk);
        n++;
      end while (!(o_frame_addr == 3'd4 && !o_cs) && n < 3000);
      check("row4_reached", {31'h0, (n < 3000)}, 32'h1);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_cs", {31'h0, o_cs}, 32'h1);
    check("midrst_busy", {31'h0, o_busy}, 32'h1);
    @(posedge clk); #1 reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    push_init(4'hF);
    wait_idle("reinit", 3000);
    compare_windows("reinit");
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("pending_dropped", got_q.size(), 0);
    check("pending_idle", {31'h0, o_busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
